// File: rtl/drv_ad56x3_multi.sv
// rtl/drv_ad56x3_multi.sv - multi-channel SPI write engine for AD56x3/AD56x4 DACs
// Latches all channels on ce, then sends one 24-bit frame per channel with a sync gap between frames.
module drv_ad56x3_multi #(
    parameter int          NUM_CH        = 2,
    parameter int          DATA_WIDTH    = 14,
    parameter logic [3:0]  SIGN_MASK     = 4'b0000,
    parameter string       UPDATE_MODE   = "IMMEDIATE",
    parameter int          SCLK_DIVIDER  = 2,
    parameter int          SYNC_DURATION = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data,
    output logic                         busy,
    output logic                         overrun,
    output logic                         dacSync,
    output logic                         dacSclk,
    output logic                         dacDin
);
    localparam int DW_ALL  = NUM_CH * DATA_WIDTH;
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIVW    = $clog2(SCLK_DIVIDER);
    localparam int GAP_CYC = SYNC_DURATION * SCLK_DIVIDER;
    localparam int GAPW    = $clog2(GAP_CYC);
    localparam bit SIMUL   = (UPDATE_MODE == "SIMULTANEOUS");

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCLK_DIVIDER - 1);
    localparam logic [DIVW:0]   HALF     = (DIVW + 1)'(SCLK_DIVIDER / 2);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state;
    logic [DW_ALL-1:0] hold;
    logic [DW_ALL-1:0] conv;
    logic [23:0]       sr;
    logic [DIVW-1:0]   div;
    logic [DIVW:0]     div_nxt;
    logic [4:0]        bitn;
    logic [GAPW-1:0]   gapc;
    logic [CHW-1:0]    ch;
    logic [23:0]       frame0;
    logic [23:0]       frame_nx;

    function automatic logic [23:0] build_frame(input logic [CHW-1:0] c,
                                                input logic [DW_ALL-1:0] samples);
        logic [2:0]  cmd;
        logic [15:0] val;
        val = 16'(samples[c*DATA_WIDTH +: DATA_WIDTH]);
        val = val << (16 - DATA_WIDTH);
        if (!SIMUL)
            cmd = 3'b011;
        else if (32'(c) == NUM_CH - 1)
            cmd = 3'b010;
        else
            cmd = 3'b000;
        return {2'b00, cmd, 3'(c), val};
    endfunction

    // Signed channels become offset binary by flipping the sample MSB.
    always_comb begin
        conv = data;
        for (int n = 0; n < NUM_CH; n++) begin
            if (SIGN_MASK[n])
                conv[n*DATA_WIDTH + DATA_WIDTH - 1] = ~data[n*DATA_WIDTH + DATA_WIDTH - 1];
        end
    end

    assign frame0   = build_frame('0, conv);
    assign frame_nx = build_frame(ch + 1'b1, hold);
    assign div_nxt  = {1'b0, div} + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            hold    <= '0;
            sr      <= '0;
            div     <= '0;
            bitn    <= '0;
            gapc    <= '0;
            ch      <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            dacSync <= 1'b1;
            dacSclk <= 1'b1;
            dacDin  <= 1'b0;
        end else begin
            overrun <= ce && (state != IDLE);
            case (state)
                IDLE: begin
                    if (ce) begin
                        hold    <= conv;
                        sr      <= frame0;
                        dacDin  <= frame0[23];
                        dacSync <= 1'b0;
                        dacSclk <= 1'b1;
                        busy    <= 1'b1;
                        div     <= '0;
                        bitn    <= '0;
                        ch      <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div     <= '0;
                        dacSclk <= 1'b1;
                        if (bitn == 5'd23) begin
                            dacSync <= 1'b1;
                            dacDin  <= 1'b0;
                            gapc    <= '0;
                            state   <= GAP;
                        end else begin
                            bitn   <= bitn + 5'd1;
                            sr     <= sr << 1;
                            dacDin <= sr[22];
                        end
                    end else begin
                        div     <= div + 1'b1;
                        dacSclk <= (div_nxt < HALF);
                    end
                end
                GAP: begin
                    if (gapc == GAP_LAST) begin
                        if (32'(ch) < NUM_CH - 1) begin
                            ch      <= ch + 1'b1;
                            sr      <= frame_nx;
                            dacDin  <= frame_nx[23];
                            dacSync <= 1'b0;
                            div     <= '0;
                            bitn    <= '0;
                            state   <= SHIFT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        gapc <= gapc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_drv_ad56x3_multi.sv
// tb/tb_drv_ad56x3_multi.sv - scoreboard bench for drv_ad56x3_multi in three configurations
module tb_drv_ad56x3_multi;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce_a = 1'b0, ce_b = 1'b0, ce_c = 1'b0;
    logic [27:0] d_a = '0, d_b = '0;
    logic [13:0] d_c = '0;
    wire  [2:0]  busy_w, ov_w, sync_w, sclk_w, din_w;

    int n_pass = 0;
    int n_total = 0;
    logic [23:0] expq [3][$];

    localparam int LOWX  [3] = '{48, 48, 96};
    localparam int GAPX  [3] = '{10, 10, 20};
    localparam int BUSYX = 116;

    always #5 clk = ~clk;

    drv_ad56x3_multi #(.NUM_CH(2), .DATA_WIDTH(14), .SIGN_MASK(4'b0000), .UPDATE_MODE("IMMEDIATE"),
                       .SCLK_DIVIDER(2), .SYNC_DURATION(5)) dut_a (
        .clk(clk), .reset(reset), .ce(ce_a), .data(d_a), .busy(busy_w[0]), .overrun(ov_w[0]),
        .dacSync(sync_w[0]), .dacSclk(sclk_w[0]), .dacDin(din_w[0]));

    drv_ad56x3_multi #(.NUM_CH(2), .DATA_WIDTH(14), .SIGN_MASK(4'b0010), .UPDATE_MODE("SIMULTANEOUS"),
                       .SCLK_DIVIDER(2), .SYNC_DURATION(5)) dut_b (
        .clk(clk), .reset(reset), .ce(ce_b), .data(d_b), .busy(busy_w[1]), .overrun(ov_w[1]),
        .dacSync(sync_w[1]), .dacSclk(sclk_w[1]), .dacDin(din_w[1]));

    drv_ad56x3_multi #(.NUM_CH(1), .DATA_WIDTH(14), .SIGN_MASK(4'b0000), .UPDATE_MODE("IMMEDIATE"),
                       .SCLK_DIVIDER(4), .SYNC_DURATION(5)) dut_c (
        .clk(clk), .reset(reset), .ce(ce_c), .data(d_c), .busy(busy_w[2]), .overrun(ov_w[2]),
        .dacSync(sync_w[2]), .dacSclk(sclk_w[2]), .dacDin(din_w[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_w != 3'b000 && n < 1000) begin
            tick();
            n++;
        end
        chk("idle_timeout", int'(busy_w == 3'b000), 1);
        repeat (2) tick();
    endtask

    // Deserialise each DUT's pins and compare complete frames against the queued expectations.
    for (genvar g = 0; g < 3; g++) begin : mon
        int          nb, lowc, highc, busyc, ovc;
        logic [23:0] sh;
        logic        ps, pk, pd, pb;
        initial ovc = 0;
        always @(negedge clk) begin
            if (!reset) begin
                nb = 0; lowc = 0; highc = 0; busyc = 0; sh = '0;
            end else begin
                if (ov_w[g]) ovc++;
                if (pk && !sclk_w[g] && !sync_w[g]) begin
                    chk("din_stable", int'(din_w[g]), int'(pd));
                    sh = {sh[22:0], din_w[g]};
                    nb++;
                end
                if (ps && !sync_w[g]) begin
                    if (pb) chk("gap_len", highc, GAPX[g]);
                    lowc = 0;
                    nb = 0;
                end
                if (!ps && sync_w[g]) begin
                    chk("frame_bits", nb, 24);
                    chk("sync_low_len", lowc, LOWX[g]);
                    if (expq[g].size() == 0) chk("frame_unexpected", int'(sh), -1);
                    else chk("frame", int'(sh), int'(expq[g].pop_front()));
                    highc = 0;
                end
                if (sync_w[g]) highc++; else lowc++;
                if (pb && !busy_w[g]) begin
                    chk("busy_len", busyc, BUSYX);
                    busyc = 0;
                end
                if (busy_w[g]) busyc++;
            end
            ps = sync_w[g]; pk = sclk_w[g]; pd = din_w[g]; pb = busy_w[g];
        end
    end

    initial begin
        int ov0;
        int n;
        repeat (3) tick();
        chk("rst_busy", int'(busy_w), 0);
        chk("rst_overrun", int'(ov_w), 0);
        chk("rst_sync", int'(sync_w), 7);
        chk("rst_sclk", int'(sclk_w), 7);
        chk("rst_din", int'(din_w), 0);
        reset = 1'b1;
        tick();

        // Basic frames in all three configurations
        d_a = {14'h0000, 14'h3FFF};
        d_b = {14'h2000, 14'h3FFF};
        d_c = 14'h1234;
        expq[0].push_back(24'h18FFFC); expq[0].push_back(24'h190000);
        expq[1].push_back(24'h00FFFC); expq[1].push_back(24'h110000);
        expq[2].push_back(24'h1848D0);
        ce_a = 1; ce_b = 1; ce_c = 1;
        tick();
        ce_a = 0; ce_b = 0; ce_c = 0;
        chk("start_busy", int'(busy_w), 7);
        chk("start_sync", int'(sync_w), 0);
        wait_idle();

        // Overrun pulses and data changes while busy
        ov0 = mon[0].ovc;
        d_a = {14'h0AAA, 14'h1555};
        d_b = {14'h1FFF, 14'h0001};
        d_c = 14'h0001;
        expq[0].push_back(24'h185554); expq[0].push_back(24'h192AA8);
        expq[1].push_back(24'h000004); expq[1].push_back(24'h11FFFC);
        expq[2].push_back(24'h180004);
        ce_a = 1; ce_b = 1; ce_c = 1;
        tick();
        ce_a = 0; ce_b = 0; ce_c = 0;
        repeat (9) tick();
        ce_a = 1; tick(); ce_a = 0;
        repeat (9) tick();
        d_a = 28'hFFFFFFF;
        repeat (29) tick();
        ce_a = 1; tick(); ce_a = 0;
        wait_idle();
        chk("overrun_count", mon[0].ovc - ov0, 2);

        // Asynchronous reset in the middle of frame 0
        d_a = {14'h0123, 14'h0456};
        ce_a = 1; tick(); ce_a = 0;
        repeat (20) tick();
        #3 reset = 1'b0;
        #1;
        chk("abort_sync", int'(sync_w[0]), 1);
        chk("abort_sclk", int'(sclk_w[0]), 1);
        chk("abort_din", int'(din_w[0]), 0);
        chk("abort_busy", int'(busy_w[0]), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        d_a = {14'h3000, 14'h0000};
        expq[0].push_back(24'h180000); expq[0].push_back(24'h19C000);
        ce_a = 1; tick(); ce_a = 0;
        wait_idle();

        // ce held high: back-to-back transactions
        ov0 = mon[0].ovc;
        d_a = {14'h0101, 14'h0202};
        repeat (2) begin
            expq[0].push_back(24'h180808); expq[0].push_back(24'h190404);
        end
        ce_a = 1;
        tick();
        n = 0;
        while (busy_w[0] && n < 300) begin
            tick();
            n++;
        end
        chk("b2b_busy_fall", int'(busy_w[0]), 0);
        tick();
        ce_a = 0;
        chk("b2b_restart", int'(busy_w[0]), 1);
        wait_idle();
        chk("b2b_overrun_count", mon[0].ovc - ov0, 116);

        for (int i = 0; i < 3; i++) chk("queue_empty", expq[i].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/drv_ad56x3_multi.md
Name: drv_ad56x3_multi

Overview:
Parametrised SPI write engine for AD56x3/AD56x4-family DACs. It drives 1 to 4 channels from one packed sample word and supports a per-channel signed/unsigned format. It has two update modes: immediate per-channel update, or simultaneous update of all channels on the last frame. A busy/overrun handshake replaces silent sample dropping. It sits between the sample-rate strobe generator and the DAC pins, as the next generation of the team's dual-channel DAC driver.

Parameters:
NUM_CH, 2, number of channels (1..4); channel n uses DAC address n.
DATA_WIDTH, 14, sample width (1..16); left-justified into the 16-bit DAC data field, unused LSBs zero.
SIGN_MASK, 4'b0000, bit n = 1 means channel n input is two's complement and is converted to offset binary by inverting its MSB.
UPDATE_MODE, "IMMEDIATE", "IMMEDIATE" or "SIMULTANEOUS".
SCLK_DIVIDER, 2, clk cycles per dacSclk period; even, >= 2.
SYNC_DURATION, 5, dacSync high time between frames, in dacSclk periods (>= 1).

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-low reset
ce  in  1  sample strobe; latches data when accepted
data  in  NUM_CH*DATA_WIDTH  packed samples; channel n at bits [n*DATA_WIDTH +: DATA_WIDTH]
busy  out  1  high while a transaction is in progress
overrun  out  1  one-cycle pulse when ce arrives while busy
dacSync  out  1  frame sync, active low
dacSclk  out  1  serial clock; idles high; DAC samples dacDin on its falling edge
dacDin  out  1  serial data, MSB first

Behaviour:
- Reset (reset=0, async): dacSync=1, dacSclk=1, dacDin=0, busy=0, overrun=0, FSM in IDLE, channel counter 0. Reset asserted mid-frame aborts the frame immediately; no partial-frame recovery is attempted.
- All outputs are registered.
- Frame format (24 bits, MSB first): [23:22]=00, [21:19]=command, [18:16]=address n, [15:0]=sample << (16-DATA_WIDTH).
- Commands:
  - IMMEDIATE: 011 (write and update channel n) for every channel.
  - SIMULTANEOUS: 000 (write input register n) for channels 0..NUM_CH-2; 010 (write input register n, update all) for the last channel.
  - NUM_CH=1 in SIMULTANEOUS mode uses 010.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: on ce=1, latch all channels (sign-converted) into a holding register and load frame 0 into the shift register. In the next cycle dacSync=0, busy=1, and dacDin = bit 23 → SHIFT.
  - SHIFT: each bit period lasts SCLK_DIVIDER cycles; dacSclk is high for the first SCLK_DIVIDER/2 cycles and low for the second half. dacDin changes only at a bit-period start (on dacSclk rising). After 24 bit periods, dacSync=1, dacSclk=1, dacDin=0 → GAP.
  - GAP: lasts SYNC_DURATION*SCLK_DIVIDER cycles. Afterwards, if channels remain, increment the channel, load the next frame, set dacSync=0 and → SHIFT. Otherwise busy=0 and → IDLE.
- busy is high for exactly NUM_CH*(24+SYNC_DURATION)*SCLK_DIVIDER cycles per transaction.
- Once busy falls, the next cycle's ce is accepted. ce in the same cycle busy falls (last GAP cycle) is treated as overrun.
- ce while busy: the sample is discarded and the transaction in progress is unaffected. overrun=1 for one cycle, once per ignored ce cycle.
- data changes while busy have no effect, because channels are sent from the holding register.
- Sign conversion is applied to the latched value only. The most negative signed value maps to 0 and the most positive maps to all-ones.

Test Plan:
- NUM_CH=2, DATA_WIDTH=14, IMMEDIATE, SIGN_MASK=0, data ch0=0x3FFF, ch1=0x0000, one ce → frames 0x18FFFC then 0x190000. dacSync low for 48 clk per frame, high 10 clk between frames. busy high for 116 cycles.
- Same configuration with SIMULTANEOUS mode, SIGN_MASK=2'b10, ch1=0x2000 → frames 0x00FFFC, 0x110000. ch1=0x1FFF gives frame 0x11FFFC.
- ce pulsed at cycles +10 and +50 after an accepted ce → two single-cycle overrun pulses. The transmitted frames are identical to the single-ce case, and data changes at +20 are not transmitted.
- SCLK_DIVIDER=4, NUM_CH=1 → dacSclk period 4 clk (2 high/2 low). dacDin is stable across each falling edge. 24 falling edges occur while dacSync is low.
- Drive reset=0 at bit 10 of frame 0, release, then issue a new ce → outputs return to their reset values asynchronously. The next transaction restarts at channel 0 with complete, correct frames.
- Back-to-back: ce held high continuously → overrun each busy cycle. A new transaction starts the cycle after busy falls, and frames are contiguous with no lost bits.
